// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: entry layout, default depth, PC step.
package bru_defs;

  localparam int PC_W     = 32;
  localparam int TGT_W    = 32;
  localparam int PRED_W   = 1;
  localparam int ENTRY_W  = PC_W + TGT_W + PRED_W;

  localparam int          BRU_DEFAULT_DEPTH = 4;
  localparam logic [31:0] PC_INC            = 32'd4;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [TGT_W-1:0] target;
    logic             pred_taken;
  } bru_entry_t;

  // A correct direction with a wrong target still redirects fetch.
  function automatic logic is_mispredict(bru_entry_t e, logic taken, logic [31:0] target);
    return (taken != e.pred_taken) || (taken && e.pred_taken && (target != e.target));
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute/predictor side bundle of the branch resolve unit.
interface branch_resolve_unit_if #(parameter int DEPTH = 4);
  localparam int PTR_W = $clog2(DEPTH);

  logic             push_valid;
  logic [31:0]      push_pc;
  logic             push_pred_taken;
  logic [31:0]      push_pred_target;
  logic             full;
  logic [PTR_W:0]   count;
  logic             res_valid;
  logic             res_taken;
  logic [31:0]      res_target;
  logic             update_en;
  logic             actual_taken;
  logic [31:0]      update_pc;
  logic             flush;
  logic [31:0]      redirect_pc;
  logic             res_err;

  modport master (
    output push_valid, push_pc, push_pred_taken, push_pred_target,
    output res_valid, res_taken, res_target,
    input  full, count, update_en, actual_taken, update_pc, flush, redirect_pc, res_err
  );

  modport slave (
    input  push_valid, push_pc, push_pred_taken, push_pred_target,
    input  res_valid, res_taken, res_target,
    output full, count, update_en, actual_taken, update_pc, flush, redirect_pc, res_err
  );
endinterface

// File: rtl/bru_pred_fifo.sv
// In-order queue of fetch predictions; synchronous clear wins over push.
module bru_pred_fifo
  import bru_defs::*;
#(
  parameter int DEPTH = BRU_DEFAULT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  bru_entry_t     push_data,
  input  logic           pop,
  input  logic           clear,
  output bru_entry_t     head,
  output logic [PTR_W:0] count,
  output logic           full
);

  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  bru_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  // NOTE: storage has no reset; occupancy is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head = mem[rd_ptr];
  assign full = (count == FULL_CNT);

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves queued predictions against execute outcomes, trains the predictor and flushes.
// Optional perf counters are enabled by defining BRU_PERF_CNT_EN.
module branch_resolve_unit
  import bru_defs::*;
#(
  parameter int DEPTH = BRU_DEFAULT_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_unit_if.slave  bus
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]           perf_branches,
  output logic [31:0]           perf_mispredicts
`endif
);

  bru_entry_t     head, push_data;
  logic [PTR_W:0] count;
  logic           full, push_ok, res_ok, mispredict_now;
  logic           update_en, actual_taken, flush, res_err;
  logic [31:0]    update_pc, redirect_pc;

  assign push_data = '{pc: bus.push_pc, target: bus.push_pred_target,
                       pred_taken: bus.push_pred_taken};

  // A pop frees the slot being written, so a full queue can still accept.
  assign res_ok         = bus.res_valid && (count != '0);
  assign mispredict_now = res_ok && is_mispredict(head, bus.res_taken, bus.res_target);
  assign push_ok        = bus.push_valid && (!full || bus.res_valid) && !mispredict_now && !flush;

  bru_pred_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_ok),
    .push_data (push_data),
    .pop       (res_ok),
    .clear     (mispredict_now),
    .head      (head),
    .count     (count),
    .full      (full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      update_en    <= 1'b0;
      actual_taken <= 1'b0;
      update_pc    <= '0;
      flush        <= 1'b0;
      redirect_pc  <= '0;
      res_err      <= 1'b0;
    end else begin
      update_en <= res_ok;
      flush     <= mispredict_now;
      if (res_ok) begin
        actual_taken <= bus.res_taken;
        update_pc    <= head.pc;
      end
      if (mispredict_now)
        redirect_pc <= bus.res_taken ? bus.res_target : head.pc + PC_INC;
      if (bus.res_valid && (count == '0)) res_err <= 1'b1;
    end
  end

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (res_ok)         perf_branches    <= perf_branches + 32'd1;
      if (mispredict_now) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`endif

  assign bus.full         = full;
  assign bus.count        = count;
  assign bus.update_en    = update_en;
  assign bus.actual_taken = actual_taken;
  assign bus.update_pc    = update_pc;
  assign bus.flush        = flush;
  assign bus.redirect_pc  = redirect_pc;
  assign bus.res_err      = res_err;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (DEPTH=4).
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_tests  = 0;
  int   n_failed = 0;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.DEPTH(4)) bus ();

`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_branches, perf_mispredicts;
`endif

  branch_resolve_unit #(.DEPTH(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus)
`ifdef BRU_PERF_CNT_EN
    ,
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; everything is driven and sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.push_valid = 1'b0;
    bus.res_valid  = 1'b0;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
    bus.push_valid       = 1'b1;
    bus.push_pc          = pc;
    bus.push_pred_taken  = pred;
    bus.push_pred_target = tgt;
  endtask

  task automatic set_res(input logic taken, input logic [31:0] tgt);
    bus.res_valid  = 1'b1;
    bus.res_taken  = taken;
    bus.res_target = tgt;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
    idle();
    set_push(pc, pred, tgt);
    step();
    idle();
  endtask

  task automatic resolve_one(input logic taken, input logic [31:0] tgt);
    idle();
    set_res(taken, tgt);
    step();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.push_pc = '0; bus.push_pred_taken = 1'b0; bus.push_pred_target = '0;
    bus.res_taken = 1'b0; bus.res_target = '0;
    step();
    rst = 1'b0;

    check("rst_count",   32'(bus.count), 32'd0);
    check("rst_full",    32'(bus.full), 32'd0);
    check("rst_upd_en",  32'(bus.update_en), 32'd0);
    check("rst_act_tk",  32'(bus.actual_taken), 32'd0);
    check("rst_upd_pc",  bus.update_pc, 32'd0);
    check("rst_flush",   32'(bus.flush), 32'd0);
    check("rst_redir",   bus.redirect_pc, 32'd0);
    check("rst_res_err", 32'(bus.res_err), 32'd0);

    // 1: correct taken prediction
    push_one(32'h100, 1'b1, 32'h200);
    check("t1_count_push", 32'(bus.count), 32'd1);
    resolve_one(1'b1, 32'h200);
    check("t1_upd_en",  32'(bus.update_en), 32'd1);
    check("t1_act_tk",  32'(bus.actual_taken), 32'd1);
    check("t1_upd_pc",  bus.update_pc, 32'h100);
    check("t1_flush",   32'(bus.flush), 32'd0);
    check("t1_count",   32'(bus.count), 32'd0);
    step();
    check("t1_upd_en_drop", 32'(bus.update_en), 32'd0);
    check("t1_upd_pc_hold", bus.update_pc, 32'h100);

    // 2: direction mispredicts, both ways
    push_one(32'h104, 1'b0, 32'h0);
    resolve_one(1'b1, 32'h300);
    check("t2a_flush",  32'(bus.flush), 32'd1);
    check("t2a_redir",  bus.redirect_pc, 32'h300);
    check("t2a_upd_pc", bus.update_pc, 32'h104);
    check("t2a_act_tk", 32'(bus.actual_taken), 32'd1);
    step();
    check("t2a_flush_1cyc", 32'(bus.flush), 32'd0);
    push_one(32'h108, 1'b1, 32'h148);
    resolve_one(1'b0, 32'h0);
    check("t2b_flush",  32'(bus.flush), 32'd1);
    check("t2b_redir",  bus.redirect_pc, 32'h10C);
    check("t2b_upd_pc", bus.update_pc, 32'h108);
    check("t2b_act_tk", 32'(bus.actual_taken), 32'd0);
    step();

    // 3: full queue, dropped push, push+pop while full (pointers wrap here)
    for (int i = 1; i <= 4; i++) push_one(32'(i * 16), 1'b1, 32'(i * 16 + 'h40));
    check("t3_full",  32'(bus.full), 32'd1);
    check("t3_count", 32'(bus.count), 32'd4);
    push_one(32'h50, 1'b1, 32'h90);
    check("t3_drop_count", 32'(bus.count), 32'd4);
    check("t3_drop_upd",   32'(bus.update_en), 32'd0);
    idle();
    set_push(32'h50, 1'b1, 32'h90);
    set_res(1'b1, 32'h50);
    step();
    idle();
    check("t3_pp_count",  32'(bus.count), 32'd4);
    check("t3_pp_upd_pc", bus.update_pc, 32'h10);
    check("t3_pp_flush",  32'(bus.flush), 32'd0);
    resolve_one(1'b1, 32'h60);
    check("t3_next_upd_pc", bus.update_pc, 32'h20);
    resolve_one(1'b1, 32'h70);
    resolve_one(1'b1, 32'h80);
    resolve_one(1'b1, 32'h90);
    check("t3_drain_upd_pc", bus.update_pc, 32'h50);
    check("t3_drain_count",  32'(bus.count), 32'd0);
    check("t3_drain_flush",  32'(bus.flush), 32'd0);

    // 4: target mispredict with younger entries; pushes in mispredict and flush cycles
    push_one(32'h60, 1'b1, 32'h80);
    push_one(32'h64, 1'b1, 32'h90);
    push_one(32'h68, 1'b0, 32'h0);
    check("t4_count3", 32'(bus.count), 32'd3);
    idle();
    set_res(1'b1, 32'h84);
    set_push(32'h6C, 1'b0, 32'h0);
    step();
    check("t4_flush", 32'(bus.flush), 32'd1);
    check("t4_redir", bus.redirect_pc, 32'h84);
    check("t4_count", 32'(bus.count), 32'd0);
    bus.res_valid = 1'b0;
    set_push(32'h70, 1'b0, 32'h0);
    step();
    idle();
    check("t4_flush_drop_count", 32'(bus.count), 32'd0);
    check("t4_flush_off",        32'(bus.flush), 32'd0);

    // 5: resolve on empty queue, then reset mid-operation
    resolve_one(1'b1, 32'h0);
    check("t5_err",    32'(bus.res_err), 32'd1);
    check("t5_no_upd", 32'(bus.update_en), 32'd0);
    step();
    check("t5_err_sticky", 32'(bus.res_err), 32'd1);
    push_one(32'hA0, 1'b1, 32'hB0);
    push_one(32'hA4, 1'b0, 32'h0);
    check("t5_count2", 32'(bus.count), 32'd2);
    set_res(1'b0, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    check("t5_rst_count", 32'(bus.count), 32'd0);
    check("t5_rst_err",   32'(bus.res_err), 32'd0);
    check("t5_rst_upd",   32'(bus.update_en), 32'd0);
    check("t5_rst_flush", 32'(bus.flush), 32'd0);
    step();
    check("t5_post_upd",   32'(bus.update_en), 32'd0);
    check("t5_post_count", 32'(bus.count), 32'd0);

`ifdef BRU_PERF_CNT_EN
    // 6: ten resolves, the first three mispredicted on target
    check("t6_rst_br", perf_branches, 32'd0);
    for (int i = 0; i < 10; i++) begin
      push_one(32'h400 + 32'(i * 8), 1'b1, 32'h800 + 32'(i * 8));
      resolve_one(1'b1, 32'h800 + 32'(i * 8) + ((i < 3) ? 32'd4 : 32'd0));
      step();
    end
    check("t6_branches",    perf_branches, 32'd10);
    check("t6_mispredicts", perf_mispredicts, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
